i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
- Downstream stage of the sound mixer: consumes the mixed 16-bit stereo samples (sample_l/sample_r, signed, clk domain) and serializes them as a standard Philips I2S stream for the card's external DAC.
- Generates BCLK/LRCK locally from clk using a fractional clock enable derived from clock_rate.
- Captures one coherent L/R pair per frame and pads each slot to SLOT_BITS.

Parameters:
SAMPLE_RATE  48000  output frame rate fs, Hz
SLOT_BITS    32     BCLK periods per channel slot (16..32); BCLK = 2*SLOT_BITS*fs

Ports:
clk           in   1   system clock
rst_n         in   1   synchronous active-low reset
clock_rate    in   28  clk frequency in Hz (quasi-static)
sample_l      in   16  signed left sample from mixer
sample_r      in   16  signed right sample from mixer
mute          in   1   1 = transmit zeros from next frame
i2s_bclk      out  1   bit clock
i2s_lrck      out  1   word select, 0 = left, 1 = right
i2s_data      out  1   serial data, MSB first, two's complement
frame_strobe  out  1   1-clk pulse when a new L/R pair is latched

Behaviour:
- Reset is synchronous, active-low, clock clk. All state is registered on clk; no derived clocks.
- Reset values: i2s_bclk=0, i2s_lrck=0, i2s_data=0, frame_strobe=0, bit counter cnt=2*SLOT_BITS-1, shadow regs=0, accumulator sum=0.
- clock_rate is registered into clk_rate each cycle.
  - If the registered value differs from the previous one, sum is cleared to 0 that cycle and no ce is issued.
- Edge enable ce uses EDGE_RATE = 4*SLOT_BITS*SAMPLE_RATE. Each cycle:
  - sum_n = sum + EDGE_RATE.
  - If sum_n >= clk_rate: sum = sum_n - clk_rate and ce=1.
  - Otherwise sum = sum_n and ce=0.
  - Widths are 28-bit with a 29-bit compare.
- clk_rate == 0, or clk_rate < 2*EDGE_RATE, is unsupported. In that case ce is suppressed entirely and all outputs hold their current values.
- On each ce, i2s_bclk toggles.
  - Rising edge (0->1): nothing else changes.
  - Falling edge (1->0): cnt advances, wrapping 2*SLOT_BITS-1 -> 0, and i2s_lrck/i2s_data update in the same clk.
- Slot decode after the advance:
  - b = cnt mod SLOT_BITS; i2s_lrck = (cnt >= SLOT_BITS).
  - i2s_data = shadow_ch[16-b] for 1 <= b <= 16, else 0.
  - This gives the I2S one-BCLK delay: the MSB appears one bit after the LRCK change, and pad bits are 0.
- Frame latch, on the falling edge where cnt wraps to 0:
  - shadow_l <= mute ? 0 : sample_l.
  - shadow_r <= mute ? 0 : sample_r.
  - frame_strobe=1 for exactly that clk.
  - Input changes at any other time do not affect the frame in flight.
- First frame after reset: the 1st ce raises BCLK; the 2nd ce is a falling edge that wraps cnt to 0 and latches the first samples.
- Latency: a sample present at the latch clk has its MSB on i2s_data 1 BCLK period (2 ce) later. The right sample starts SLOT_BITS BCLK after the left.
- Reset mid-frame: outputs return to reset values on the next clk with no partial bits. The restart follows the first-frame rule.
- Simultaneous mute change and latch: the mute value sampled in the latch clk applies.

Test Plan:
- Rate check, clock_rate=50_000_000, defaults, 1 ms run: exactly 6144 ce, 3072 BCLK rising edges, 48 frame_strobe pulses. ce spacing is 8 or 9 clk only.
- Data, sample_l=16'h8001, sample_r=16'h7FFE: decoded on BCLK rising edges, the left slot shows bits 1..16 = 1000_0000_0000_0001 then 16 zeros. The right slot (lrck=1) shows 0111_1111_1111_1110 then zeros. Bit 0 of each slot is 0.
- Coherency: change sample_l from 16'h1234 to 16'hABCD mid-left-slot. The current frame still sends 16'h1234; the next frame sends 16'hABCD. frame_strobe pulses only at the cnt wrap.
- Mute: assert mute mid-frame with samples 16'hFFFF. The current frame is unchanged; the following frames are all zero. Deassert mute and the samples return at the next latch.
- Reset mid-right-slot: rst_n=0 for 1 clk gives bclk=lrck=data=0 next clk. After release, the first falling edge (2nd ce) latches and starts the left slot.
- clock_rate change 50_000_000 -> 0 -> 33_333_333:
  - At 0: outputs freeze and there are no strobes.
  - At 33.33 MHz: sum restarts at 0, and over 33_333_333 clk the ce count is 6,144,000 ±1.

Source files
------------

// File: rtl/i2s_audio_if.sv
// Sample input and I2S output bundle between the mixer, the serializer and the DAC pins.
// master drives samples and mute; slave is the serializer that drives the I2S pins.
interface i2s_audio_if;
    logic signed [15:0] sample_l;
    logic signed [15:0] sample_r;
    logic               mute;
    logic               i2s_bclk;
    logic               i2s_lrck;
    logic               i2s_data;
    logic               frame_strobe;

    modport master (
        output sample_l, sample_r, mute,
        input  i2s_bclk, i2s_lrck, i2s_data, frame_strobe
    );

    modport slave (
        input  sample_l, sample_r, mute,
        output i2s_bclk, i2s_lrck, i2s_data, frame_strobe
    );
endinterface

// File: rtl/i2s_audio_tx.sv
// Philips I2S serializer for 16-bit stereo samples, BCLK/LRCK made from a fractional enable on clk.
// Latency: sample latched at the frame wrap, MSB on i2s_data one BCLK period later.
// No backpressure: the mixer is sampled once per frame, values between latches are ignored.
module i2s_audio_tx #(
    parameter int unsigned SAMPLE_RATE = 48000,
    parameter int unsigned SLOT_BITS   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] clock_rate,
    i2s_audio_if.slave  aud
);
    localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
    localparam int          CW         = $clog2(FRAME_BITS);
    localparam logic [28:0] EDGE_RATE  = 29'(4 * SLOT_BITS * SAMPLE_RATE);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    logic [27:0]        clk_rate;
    logic [27:0]        clk_rate_prev;
    logic [27:0]        sum;
    logic [28:0]        sum_n;
    logic               rate_chg;
    logic               rate_bad;
    logic               ce;

    logic               bclk;
    logic               lrck;
    logic               data;
    logic               strobe;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_n;
    logic               wrap;
    logic               fall;
    logic               lrck_n;
    logic               data_n;
    logic signed [15:0] shadow_l;
    logic signed [15:0] shadow_r;
    logic signed [15:0] ch;
    int unsigned        bit_idx;

    // Edge enable: fractional accumulator, two ce per BCLK period.
    always_comb begin
        sum_n    = {1'b0, sum} + EDGE_RATE;
        rate_chg = (clk_rate != clk_rate_prev);
        rate_bad = (clk_rate == 28'd0) || ({1'b0, clk_rate} < (EDGE_RATE << 1));
        ce       = !rate_chg && !rate_bad && (sum_n >= {1'b0, clk_rate});
    end

    // Slot decode for the position the counter moves to on the next falling edge.
    always_comb begin
        wrap    = (cnt == CNT_LAST);
        cnt_n   = wrap ? '0 : cnt + 1'b1;
        fall    = ce && bclk;
        bit_idx = 32'(cnt_n) % SLOT_BITS;
        lrck_n  = (32'(cnt_n) >= SLOT_BITS);
        ch      = lrck_n ? shadow_r : shadow_l;
        data_n  = 1'b0;
        if (bit_idx >= 1 && bit_idx <= 16) begin
            data_n = ch[4'(16 - bit_idx)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_rate      <= '0;
            clk_rate_prev <= '0;
            sum           <= '0;
            bclk          <= 1'b0;
            lrck          <= 1'b0;
            data          <= 1'b0;
            strobe        <= 1'b0;
            cnt           <= CNT_LAST;
            shadow_l      <= '0;
            shadow_r      <= '0;
        end else begin
            clk_rate      <= clock_rate;
            clk_rate_prev <= clk_rate;
            strobe        <= 1'b0;
            if (rate_chg) begin
                sum <= '0;
            end else if (!rate_bad) begin
                sum <= ce ? 28'(sum_n - {1'b0, clk_rate}) : sum_n[27:0];
            end
            if (ce) begin
                bclk <= ~bclk;
            end
            if (fall) begin
                cnt  <= cnt_n;
                lrck <= lrck_n;
                data <= data_n;
                // Whole L/R pair captured together so the frame in flight stays coherent.
                if (wrap) begin
                    shadow_l <= aud.mute ? 16'sd0 : aud.sample_l;
                    shadow_r <= aud.mute ? 16'sd0 : aud.sample_r;
                    strobe   <= 1'b1;
                end
            end
        end
    end

    assign aud.i2s_bclk     = bclk;
    assign aud.i2s_lrck     = lrck;
    assign aud.i2s_data     = data;
    assign aud.frame_strobe = strobe;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: frame scoreboard decoding the serial stream, plus rate/reset checks.
module tb_i2s_audio_tx;
    localparam longint EDGE_RATE = 4 * 32 * 48000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [27:0] clock_rate = 28'd50_000_000;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    i2s_audio_if bus();

    i2s_audio_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clock_rate (clock_rate),
        .aud        (bus)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Decodes one 64-bit frame on BCLK rising edges, starting at each frame_strobe.
    task automatic monitor_loop();
        logic        pb = 1'b0;
        logic        armed = 1'b0;
        int          pos = 0;
        logic [63:0] fb = '0;
        logic [63:0] lb = '0;
        logic [63:0] ef;
        logic [31:0] pair;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                armed = 1'b0;
            end else begin
                if (bus.frame_strobe) begin
                    armed = 1'b1;
                    pos   = 0;
                end
                if (armed && bus.i2s_bclk && !pb) begin
                    fb[pos] = bus.i2s_data;
                    lb[pos] = bus.i2s_lrck;
                    pos++;
                    if (pos == 64) begin
                        armed = 1'b0;
                        if (exp_q.size() > 0) begin
                            pair = exp_q.pop_front();
                            ef = '0;
                            for (int i = 0; i < 16; i++) begin
                                ef[1 + i]  = pair[31 - i];
                                ef[33 + i] = pair[15 - i];
                            end
                            check("frame_data", fb, ef);
                            check("frame_lrck", lb, {32'hFFFF_FFFF, 32'h0000_0000});
                        end
                    end
                end
            end
            pb = bus.i2s_bclk;
        end
    endtask

    task automatic wait_strobe(output int toggles);
        int   n = 0;
        logic pb;
        toggles = 0;
        pb = bus.i2s_bclk;
        do begin
            @(negedge clk);
            n++;
            if (bus.i2s_bclk !== pb) toggles++;
            pb = bus.i2s_bclk;
        end while (bus.frame_strobe !== 1'b1 && n < 3000);
        if (bus.frame_strobe !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_timeout: got no frame_strobe in %0d clk, required one", n);
        end
    endtask

    task automatic expect_frame(input logic [15:0] l, input logic [15:0] r);
        int t;
        wait_strobe(t);
        exp_q.push_back({l, r});
    endtask

    task automatic measure(input int cycles, output int tog, output int rise, output int strb,
                           output int chg, output int smin, output int smax);
        logic       pb;
        logic [2:0] po;
        int         last = -1;
        tog = 0; rise = 0; strb = 0; chg = 0; smin = 1000; smax = 0;
        pb = bus.i2s_bclk;
        po = {bus.i2s_bclk, bus.i2s_lrck, bus.i2s_data};
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.i2s_bclk !== pb) begin
                tog++;
                if (bus.i2s_bclk) rise++;
                if (last >= 0) begin
                    if (i - last < smin) smin = i - last;
                    if (i - last > smax) smax = i - last;
                end
                last = i;
            end
            if (bus.frame_strobe) strb++;
            if ({bus.i2s_bclk, bus.i2s_lrck, bus.i2s_data} !== po) chg++;
            pb = bus.i2s_bclk;
            po = {bus.i2s_bclk, bus.i2s_lrck, bus.i2s_data};
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        int t, tog, rise, strb, chg, smin, smax;
        bus.sample_l = 16'h8001;
        bus.sample_r = 16'h7FFE;
        bus.mute     = 1'b0;
        fork
            monitor_loop();
        join_none
        idle(3);
        check("reset_bclk", 64'(bus.i2s_bclk), 64'd0);
        check("reset_lrck", 64'(bus.i2s_lrck), 64'd0);
        check("reset_data", 64'(bus.i2s_data), 64'd0);
        check("reset_strobe", 64'(bus.frame_strobe), 64'd0);
        rst_n = 1'b1;

        // First frame: latch on the second ce, then the 8001/7FFE pattern.
        wait_strobe(t);
        check("first_latch_ce", 64'(t), 64'd2);
        exp_q.push_back({16'h8001, 16'h7FFE});

        // Coherency: left sample changes mid-left-slot.
        bus.sample_l = 16'h1234;
        bus.sample_r = 16'h5555;
        expect_frame(16'h1234, 16'h5555);
        idle(130);
        bus.sample_l = 16'hABCD;
        expect_frame(16'hABCD, 16'h5555);

        // Mute asserted and released mid-frame.
        bus.sample_l = 16'hFFFF;
        bus.sample_r = 16'hFFFF;
        expect_frame(16'hFFFF, 16'hFFFF);
        idle(130);
        bus.mute = 1'b1;
        expect_frame(16'h0000, 16'h0000);
        expect_frame(16'h0000, 16'h0000);
        idle(130);
        bus.mute = 1'b0;
        expect_frame(16'hFFFF, 16'hFFFF);

        // 1 ms at 50 MHz.
        measure(50000, tog, rise, strb, chg, smin, smax);
        check("rate_ce", 64'(tog), 64'd6144);
        check("rate_rise", 64'(rise), 64'd3072);
        check("rate_strobes", 64'(strb), 64'd48);
        check_range("rate_space_min", smin, 8, 9);
        check_range("rate_space_max", smax, 8, 9);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        // Reset for one clk in the middle of the right slot.
        wait_strobe(t);
        t = 0;
        while (bus.i2s_lrck !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("right_slot_reached", 64'(bus.i2s_lrck), 64'd1);
        idle(40);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_out", {61'd0, bus.i2s_bclk, bus.i2s_lrck, bus.i2s_data}, 64'd0);
        check("midreset_strobe", 64'(bus.frame_strobe), 64'd0);
        wait_strobe(t);
        check("midreset_latch_ce", 64'(t), 64'd2);
        check("midreset_lrck", 64'(bus.i2s_lrck), 64'd0);

        // Unsupported rate freezes everything.
        clock_rate = 28'd0;
        idle(4);
        measure(2000, tog, rise, strb, chg, smin, smax);
        check("zero_rate_ce", 64'(tog), 64'd0);
        check("zero_rate_strobes", 64'(strb), 64'd0);
        check("zero_rate_out_changes", 64'(chg), 64'd0);

        clock_rate = 28'd33_333_333;
        measure(10000, tog, rise, strb, chg, smin, smax);
        check_range("rate33_ce", tog, (10000 * EDGE_RATE) / 33333333 - 1,
                    (10000 * EDGE_RATE) / 33333333 + 1);
        check_range("rate33_space_min", smin, 5, 6);
        check_range("rate33_space_max", smax, 5, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
